// File: rtl/conway_pkg.sv
// Shared types and constants for the Conway life engine controller.
package conway_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARMED,
    RUN,
    PAUSE,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } cell_addr_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/conway_gen_counter.sv
// Generation counter with a limit latched on clear and a registered terminal-count flag.
module conway_gen_counter #(
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [GEN_W-1:0] limit,
  output logic [GEN_W-1:0] count,
  output logic             hit
);

  localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

  logic [GEN_W-1:0] count_reg;
  logic [GEN_W-1:0] count_next;
  logic [GEN_W-1:0] limit_reg;
  logic [GEN_W-1:0] limit_next;
  logic             hit_reg;

  // A clear and an increment on the same edge yield a count of one.
  always_comb begin
    limit_next = clr ? limit : limit_reg;
    count_next = clr ? '0 : count_reg;
    if (inc) begin
      count_next = count_next + GEN_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      limit_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      limit_reg <= limit_next;
      hit_reg   <= (limit_next != '0) && (count_next == limit_next);
    end
  end

  assign count = count_reg;
  assign hit   = hit_reg;

endmodule

// File: rtl/conway_ctrl.sv
// Sequencer feeding seed cells into the life engine, then running it for a bounded
// or free-running number of generations with pause, single-step and abort.
module conway_ctrl
  import conway_pkg::*;
#(
  parameter int GEN_W    = 16,
  parameter int MAX_SEED = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  input  logic [ADDR_W-1:0] seed_addr,
  input  logic              seed_last,
  output logic              seed_ready,
  input  logic              start,
  input  logic [GEN_W-1:0]  gen_limit,
  input  logic              pause,
  input  logic              step,
  input  logic              abort,
  output logic              eng_state,
  output logic [ADDR_W-1:0] eng_addr,
  output logic              eng_en,
  output logic [GEN_W-1:0]  gen_count,
  output logic              busy,
  output logic              done,
  output logic              seed_ovf
);

  localparam int CNT_W = $clog2(MAX_SEED + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_SEED - 1);

  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic [CNT_W-1:0] seed_cnt_reg;
  logic [CNT_W-1:0] seed_cnt_next;
  logic [CNT_W-1:0] seed_cnt_base;
  cell_addr_t       eng_addr_reg;
  logic             seed_ready_reg;
  logic             eng_state_reg;
  logic             eng_en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             seed_ovf_reg;

  logic seed_hs;
  logic start_ok;
  logic load_wr;
  logic gen_issue;
  logic gen_clr;
  logic gen_hit;
  logic ovf_set;
  logic ovf_clr;

  conway_gen_counter #(
    .GEN_W(GEN_W)
  ) u_gen_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (gen_clr),
    .inc  (gen_issue),
    .limit(gen_limit),
    .count(gen_count),
    .hit  (gen_hit)
  );

  assign seed_hs  = seed_valid & seed_ready_reg;
  assign start_ok = (state_reg == ARMED) || (state_reg == DONE);
  // A handshake from IDLE or DONE begins a fresh pattern, so the count restarts.
  assign seed_cnt_base = (state_reg == LOAD) ? seed_cnt_reg : '0;

  always_comb begin
    state_next    = state_reg;
    seed_cnt_next = seed_cnt_reg;
    load_wr       = 1'b0;
    gen_issue     = 1'b0;
    gen_clr       = 1'b0;
    ovf_set       = 1'b0;
    ovf_clr       = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else if (start_ok && start) begin
      gen_clr = 1'b1;
      ovf_clr = 1'b1;
      if (pause) begin
        state_next = PAUSE;
      end else begin
        state_next = RUN;
        gen_issue  = 1'b1;
      end
    end else if (seed_hs) begin
      load_wr       = 1'b1;
      seed_cnt_next = seed_cnt_base + CNT_ONE;
      if (seed_last) begin
        state_next = ARMED;
      end else if (seed_cnt_base == CNT_LAST) begin
        state_next = ARMED;
        ovf_set    = 1'b1;
      end else begin
        state_next = LOAD;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (gen_hit) begin
            state_next = DONE;
          end else if (pause) begin
            state_next = PAUSE;
          end else begin
            gen_issue = 1'b1;
          end
        end
        PAUSE: begin
          // Releasing pause resumes at once; a coincident step adds nothing extra.
          if (gen_hit) begin
            state_next = DONE;
          end else if (!pause) begin
            state_next = RUN;
            gen_issue  = 1'b1;
          end else if (step) begin
            gen_issue = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      seed_cnt_reg   <= '0;
      seed_ready_reg <= 1'b0;
      eng_state_reg  <= MODE_LOAD;
      eng_addr_reg   <= '0;
      eng_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      seed_ovf_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      seed_cnt_reg   <= seed_cnt_next;
      seed_ready_reg <= (state_next == IDLE) || (state_next == LOAD) || (state_next == DONE);
      eng_state_reg  <= ((state_next == RUN) || (state_next == PAUSE) || (state_next == DONE))
                        ? MODE_RUN : MODE_LOAD;
      eng_en_reg     <= load_wr | gen_issue;
      busy_reg       <= (state_next == LOAD) || (state_next == RUN) || (state_next == PAUSE);
      done_reg       <= (state_next == DONE);
      if (load_wr) begin
        eng_addr_reg <= seed_addr;
      end
      if (ovf_set) begin
        seed_ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        seed_ovf_reg <= 1'b0;
      end
    end
  end

  assign seed_ready = seed_ready_reg;
  assign eng_state  = eng_state_reg;
  assign eng_addr   = eng_addr_reg;
  assign eng_en     = eng_en_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign seed_ovf   = seed_ovf_reg;

endmodule
